inst_loader: RTL
================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width in bits (fixed at 32 for byte assembly).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, width of the byte address driven to the instruction memory write port.
REQ-003 SHALL have parameter MEM_SIZE, default 256, number of instruction words in the target memory.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-007 num_words  input  9  number of words to load; sampled on accepted start.
REQ-008 abort  input  1  cancels a load in progress; returns to IDLE.
REQ-009 byte_data  input  8  incoming program byte.
REQ-010 byte_valid  input  1  byte_data valid.
REQ-011 byte_ready  output  1  loader accepts byte this cycle.
REQ-012 mem_we  output  1  write strobe to the instruction memory.
REQ-013 mem_address  output  ADDRESS_WIDTH  byte address of the word being written (word index × 4).
REQ-014 mem_wdata  output  DATA_WIDTH  assembled instruction word.
REQ-015 busy  output  1  high in RECV or WRITE.
REQ-016 done  output  1  high in DONE.
REQ-017 error  output  1  sticky flag: last start had an illegal num_words.

Function
REQ-018 States SHALL be IDLE, RECV, WRITE, DONE.
REQ-019 IDLE/DONE + start with 1 ≤ num_words ≤ MEM_SIZE -> RECV next cycle; word index, byte count and error cleared; num_words latched.
REQ-020 IDLE/DONE + start with num_words == 0 or > MEM_SIZE -> IDLE, error = 1; no write issued.
REQ-021 start in RECV or WRITE SHALL be ignored.
REQ-022 byte_ready SHALL be 1 only in RECV and SHALL be a function of state alone (no combinational path from byte_valid).
REQ-023 Byte transfer occurs on a clock edge with byte_valid & byte_ready both 1; otherwise no byte is consumed.
REQ-024 Assembly little-endian: k-th accepted byte of a word (k = 0..3) SHALL land in mem_wdata[8k+7:8k].
REQ-025 On 4th accepted byte: state -> WRITE next cycle; byte count wraps to 0.
REQ-026 WRITE lasts exactly one cycle: mem_we = 1, mem_address = word_index << 2 (zero-extended to ADDRESS_WIDTH), mem_wdata = assembled word stable.
REQ-027 After WRITE: if word_index + 1 == latched num_words -> DONE, else word_index increments and state -> RECV.
REQ-028 mem_we SHALL be 0 in all states other than WRITE.
REQ-029 Latency: 4th byte accepted at edge N -> mem_we high during cycle N+1; next byte accepted no earlier than edge N+2.
REQ-030 DONE holds done = 1 until an accepted start or abort.
REQ-031 abort in RECV or WRITE -> IDLE next edge; any write in that cycle still completes; partial word discarded; error unchanged.
REQ-032 abort and byte handshake in same cycle: abort wins; byte discarded.
REQ-033 abort in IDLE or DONE -> IDLE; done cleared.
REQ-034 Highest written mem_address SHALL be (MEM_SIZE-1)×4; no write beyond.

Reset
REQ-035 rst_n low SHALL immediately force IDLE regardless of clk; byte_ready, mem_we, busy, done, error = 0; mem_address, mem_wdata, word index, byte count = 0.
REQ-036 Reset mid-load SHALL discard all progress; no mem_we pulse during or on release of reset.
REQ-037 First start SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-038 start, num_words=2, bytes 13,00,00,00,93,00,10,00 streamed with valid always 1 -> writes 0x00000013 @0x0, 0x00100093 @0x4; done=1; 10 cycles start->done.
REQ-039 num_words=3, byte_valid toggling randomly -> same data/addresses as contiguous case; mem_we only when WRITE; no byte lost or duplicated.
REQ-040 start with num_words=0, then num_words=257 -> no mem_we, state IDLE, error=1 each time; next legal start clears error.
REQ-041 num_words=256, full stream -> last write @0x3FC, done=1, exactly 256 mem_we pulses.
REQ-042 abort after 2 bytes of word 1 (same cycle as a handshake) -> IDLE, no write of word 1; restart loads word 0 @0x0.
REQ-043 rst_n low during WRITE of word 5 -> mem_we drops asynchronously, all outputs 0; restart writes from @0x0.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: receives a byte stream, assembles little-endian 32-bit
// instruction words and writes them one by one into an instruction memory.
// A load is requested with start/num_words; abort cancels it at any time.
module inst_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [8:0]               num_words,
    input  logic                     abort,
    input  logic [7:0]               byte_data,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    // Word index only needs to reach MEM_SIZE-1.
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      word_idx_q;
    logic [1:0]            byte_cnt_q;
    logic [8:0]            num_words_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  error_q;

    logic idle_or_done;
    logic start_req;
    logic start_legal;
    logic byte_fire;
    logic last_word;

    // Decoded events shared by the FSM and the datapath. Abort has priority
    // over both a start request and a byte handshake.
    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
    assign start_req    = start && idle_or_done && !abort;
    assign start_legal  = (num_words != 9'd0) && (32'(num_words) <= MEM_SIZE);
    assign byte_fire    = byte_valid && (state_q == RECV) && !abort;
    assign last_word    = (32'(word_idx_q) + 32'd1) == 32'(num_words_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would infer a latch.
        state_d    = state_q;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = start_legal ? RECV : IDLE;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (byte_fire && (byte_cnt_q == 2'd3)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (last_word) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load bookkeeping, byte assembly and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            num_words_q <= '0;
            wdata_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            if (start_req) begin
                if (start_legal) begin
                    word_idx_q  <= '0;
                    byte_cnt_q  <= '0;
                    num_words_q <= num_words;
                    error_q     <= 1'b0;
                end else begin
                    error_q <= 1'b1;
                end
            end

            // Little-endian: k-th byte of a word lands in bits [8k+7:8k];
            // the 2-bit counter wraps to 0 after the fourth byte.
            if (byte_fire) begin
                wdata_q[8*byte_cnt_q +: 8] <= byte_data;
                byte_cnt_q                 <= byte_cnt_q + 2'd1;
            end

            if ((state_q == WRITE) && !abort && !last_word) begin
                word_idx_q <= word_idx_q + IDX_W'(1);
            end

            // A partial word is dropped when the load is cancelled.
            if (abort && busy) begin
                byte_cnt_q <= '0;
            end
        end
    end

    assign mem_address = ADDRESS_WIDTH'({word_idx_q, 2'b00});
    assign mem_wdata   = wdata_q;
    assign error       = error_q;

endmodule
